// File: rtl/high_speed_bus_ecc_pkg.sv
// Shared constants, ECC generator and status-state type for the bus ECC checker.
// Used by the encoder side and by the checker pipeline (high_speed_bus_ecc_checker).
package high_speed_bus_ecc_pkg;

    localparam int DATA_W = 32;
    localparam int ECC_W  = 7;
    localparam int CODE_W = 39;

    typedef enum logic {
        ST_CLEAN   = 1'b0,
        ST_LATCHED = 1'b1
    } status_t;

    // Result bit i is check bit e<i>; e0 covers all data bits.
    function automatic logic [ECC_W-1:0] ecc_gen(
        input logic [DATA_W-1:0] d
    );
        ecc_gen = {
            ^{d[31:16], d[7:0]},
            d[0],
            ^d[1:0],
            ^d[3:0],
            ^d[7:0],
            ^d[15:0],
            ^d[31:0]
        };
    endfunction

endpackage

// File: rtl/high_speed_bus_ecc_checker_if.sv
// Valid/ready bus bundle for the ECC checker: codeword input and checked-word output.
// slave: checker side; master: producer/consumer side (testbench or surrounding fabric).
interface high_speed_bus_ecc_checker_if;
    import high_speed_bus_ecc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] code_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              ecc_error;
    logic [ECC_W-1:0]  syndrome;

    modport slave (
        input  in_valid,
        output in_ready,
        input  code_in,
        output out_valid,
        input  out_ready,
        output data_out,
        output ecc_error,
        output syndrome
    );

    modport master (
        output in_valid,
        input  in_ready,
        output code_in,
        input  out_valid,
        output out_ready,
        input  data_out,
        input  ecc_error,
        input  syndrome
    );

endinterface

// File: rtl/high_speed_bus_ecc_checker_syndrome.sv
// ecc_syndrome_calc: combinational split of a codeword into data and syndrome.
// Ports: code (in), data / syndrome / err (out); err is the OR of the syndrome.
module ecc_syndrome_calc
    import high_speed_bus_ecc_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic [ECC_W-1:0]  syndrome,
    output logic              err
);

    assign data     = code[CODE_W-1:ECC_W];
    assign syndrome = ecc_gen(data) ^ code[ECC_W-1:0];
    assign err      = |syndrome;

endmodule

// File: rtl/high_speed_bus_ecc_checker.sv
// Two-stage ECC checker: S1 holds the codeword, S2 the data/syndrome; sticky error status.
// Ports: clk, reset_n, bus (slave), clear, err_irq, first_syndrome, err_count (ECC_ERR_COUNT_EN).
module high_speed_bus_ecc_checker
    import high_speed_bus_ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    high_speed_bus_ecc_checker_if.slave bus,
    input  logic                    clear,
    output logic                    err_irq,
    output logic [ECC_W-1:0]        first_syndrome
`ifdef ECC_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0]        err_count
`endif
);

    logic              rdy_en;
    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic [ECC_W-1:0]  s2_syn;
    logic              s2_err;

    logic [DATA_W-1:0] c_data;
    logic [ECC_W-1:0]  c_syn;
    logic              c_err;

    logic              s2_ready;
    logic              in_fire;
    logic              out_fire;
    logic              err_fire;

    status_t           state;
    logic [ECC_W-1:0]  first_syn_q;

    ecc_syndrome_calc u_calc (
        .code     (s1_code),
        .data     (c_data),
        .syndrome (c_syn),
        .err      (c_err)
    );

    // rdy_en keeps in_ready low in reset and for the cycle up to
    // the first edge after release.
    assign s2_ready     = !s2_valid || bus.out_ready;
    assign bus.in_ready = rdy_en && (!s1_valid || s2_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = s2_valid && bus.out_ready;
    assign err_fire     = out_fire && s2_err;

    assign bus.out_valid = s2_valid;
    assign bus.data_out  = s2_data;
    assign bus.syndrome  = s2_syn;
    assign bus.ecc_error = s2_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_syn   <= '0;
            s2_err   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            // When S1 cannot drain it keeps its word; otherwise it
            // takes whatever the producer offers.
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (in_fire) begin
                s1_code <= bus.code_in;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= c_data;
                    s2_syn  <= c_syn;
                    s2_err  <= c_err;
                end
            end
        end
    end

    // Clear has priority over an errored transfer in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_CLEAN;
            first_syn_q <= '0;
        end else if (clear) begin
            state       <= ST_CLEAN;
            first_syn_q <= '0;
        end else if (err_fire) begin
            unique case (state)
                ST_CLEAN: begin
                    state       <= ST_LATCHED;
                    first_syn_q <= s2_syn;
                end
                ST_LATCHED: begin
                    state <= ST_LATCHED;
                end
                default: begin
                    state <= ST_CLEAN;
                end
            endcase
        end
    end

    assign err_irq        = (state == ST_LATCHED);
    assign first_syndrome = first_syn_q;

`ifdef ECC_ERR_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (err_fire && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_count = cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_high_speed_bus_ecc_checker.sv
// Self-checking bench for high_speed_bus_ecc_checker: vector table,
// randomized backpressure stream against a parity-mask reference, corner sequences.
module tb_high_speed_bus_ecc_checker;

`ifdef ECC_ERR_COUNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    localparam logic [31:0] MASKS [7] = '{
        32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_00FF, 32'h0000_000F,
        32'h0000_0003, 32'h0000_0001, 32'hFFFF_00FF
    };

    typedef struct {
        logic [31:0] d;
        logic [6:0]  s;
        logic        e;
    } exp_t;

    typedef struct {
        logic [38:0] code;
        logic [31:0] data;
        logic [6:0]  syn;
        logic        err;
        logic        irq;
        logic [6:0]  first;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       err_irq;
    logic [6:0] first_syndrome;
`ifdef ECC_ERR_COUNT_EN
    logic [CNT_W-1:0] err_count;
`endif

    always #5 clk = ~clk;

    high_speed_bus_ecc_checker_if dif();

    high_speed_bus_ecc_checker #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (dif),
        .clear          (clear),
        .err_irq        (err_irq),
        .first_syndrome (first_syndrome)
`ifdef ECC_ERR_COUNT_EN
        ,
        .err_count      (err_count)
`endif
    );

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    int   occ = 0;
    logic m_irq = 1'b0;
    logic [6:0] m_first = '0;
    int   m_cnt = 0;
    logic held = 1'b0;
    exp_t held_v;
    logic last_in_fire = 1'b0;
    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Each check bit is the parity of the data bits its mask selects.
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) begin
            r[i] = 1'($countones(d & MASKS[i]) % 2);
        end
        return r;
    endfunction

    function automatic exp_t expect_of(input logic [38:0] c);
        exp_t x;
        x.d = c[38:7];
        x.s = ref_ecc(c[38:7]) ^ c[6:0];
        x.e = (x.s != 7'h0);
        return x;
    endfunction

    function automatic logic [38:0] make_code(input logic [31:0] d,
                                              input logic inj);
        logic [6:0] flip;
        flip = inj ? 7'($urandom_range(1, 127)) : 7'h0;
        return {d, ref_ecc(d) ^ flip};
    endfunction

    // Inputs change at posedge+1; everything is sampled at the negedge.
    task automatic step();
        exp_t x;
        logic in_fire;
        logic out_fire;
        @(negedge clk);
        check("in_ready", dif.in_ready, !(occ == 2 && !dif.out_ready));
        check("err_irq", err_irq, m_irq);
        check("first_syn", first_syndrome, m_first);
`ifdef ECC_ERR_COUNT_EN
        check("err_count", err_count, m_cnt[CNT_W-1:0]);
`endif
        if (held) begin
            check("hold_valid", dif.out_valid, 1'b1);
            check("hold_data", dif.data_out, held_v.d);
            check("hold_syn", dif.syndrome, held_v.s);
        end
        in_fire  = dif.in_valid && dif.in_ready;
        out_fire = dif.out_valid && dif.out_ready;
        if (out_fire) begin
            if (q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                x = q.pop_front();
                check("data_out", dif.data_out, x.d);
                check("syndrome", dif.syndrome, x.s);
                check("ecc_error", dif.ecc_error, x.e);
                if (x.e) begin
                    if (!m_irq) begin
                        m_irq   = 1'b1;
                        m_first = x.s;
                    end
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                end
            end
            occ--;
        end
        if (clear) begin
            m_irq   = 1'b0;
            m_first = '0;
            m_cnt   = 0;
        end
        held = dif.out_valid && !dif.out_ready;
        held_v.d = dif.data_out;
        held_v.s = dif.syndrome;
        held_v.e = dif.ecc_error;
        if (in_fire) begin
            q.push_back(expect_of(dif.code_in));
            occ++;
        end
        last_in_fire = in_fire;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        logic [38:0] cur;

        vt[0] = '{39'h00000000FF, 32'h00000001, 7'h00, 1'b0, 1'b0, 7'h00};
        vt[1] = '{39'h0000000001, 32'h00000000, 7'h01, 1'b1, 1'b1, 7'h01};
        vt[2] = '{39'h4000000000, 32'h80000000, 7'h41, 1'b1, 1'b1, 7'h01};
        vt[3] = '{{32'hFFFFFFFF, 7'h20}, 32'hFFFFFFFF, 7'h00, 1'b0,
                  1'b1, 7'h01};
        vt[4] = '{{32'h12345678, 7'h00}, 32'h12345678, 7'h49, 1'b1,
                  1'b1, 7'h01};

        dif.in_valid  = 1'b0;
        dif.code_in   = '0;
        dif.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", dif.in_ready, 1'b0);
        check("rst_out_valid", dif.out_valid, 1'b0);
        check("rst_data", dif.data_out, 32'h0);
        check("rst_syn", dif.syndrome, 7'h0);
        check("rst_ecc_err", dif.ecc_error, 1'b0);
        check("rst_irq", err_irq, 1'b0);
        check("rst_first", first_syndrome, 7'h0);
`ifdef ECC_ERR_COUNT_EN
        check("rst_count", err_count, '0);
`endif
        reset_n = 1'b1;
        #1;
        check("rel_in_ready_low", dif.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", dif.in_ready, 1'b1);

        dif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dif.in_valid = 1'b1;
            dif.code_in  = vt[i].code;
            step();
            dif.in_valid = 1'b0;
            step();
            check($sformatf("v%0d_valid", i), dif.out_valid, 1'b1);
            check($sformatf("v%0d_data", i), dif.data_out, vt[i].data);
            check($sformatf("v%0d_syn", i), dif.syndrome, vt[i].syn);
            check($sformatf("v%0d_err", i), dif.ecc_error, vt[i].err);
            step();
            check($sformatf("v%0d_irq", i), err_irq, vt[i].irq);
            check($sformatf("v%0d_first", i), first_syndrome, vt[i].first);
        end

        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.code_in   = 39'h0000000002;
        step();
        dif.in_valid = 1'b0;
        step();
        step();
        check("col_irq_before", err_irq, 1'b1);
        dif.out_ready = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("col_irq", err_irq, 1'b0);
        check("col_first", first_syndrome, 7'h0);
`ifdef ECC_ERR_COUNT_EN
        check("col_count", err_count, '0);
`endif

        acc = 0;
        last_in_fire = 1'b1;
        for (int cyc = 0; cyc < 2000 && acc < 60; cyc++) begin
            if (last_in_fire || !dif.in_valid) begin
                cur = make_code($urandom, ($urandom % 3) == 0);
            end
            dif.code_in   = cur;
            dif.in_valid  = ($urandom % 4) != 0;
            dif.out_ready = ($urandom % 2) != 0;
            clear         = ($urandom % 16) == 0;
            step();
            if (last_in_fire) acc++;
        end
        clear = 1'b0;
        check("stream_words", 32'(acc), 32'd60);
        drain();

`ifdef ECC_ERR_COUNT_EN
        clear = 1'b1;
        step();
        clear = 1'b0;
        acc = 0;
        dif.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && acc < 20; cyc++) begin
            dif.in_valid = 1'b1;
            dif.code_in  = make_code($urandom, 1'b1);
            step();
            if (last_in_fire) acc++;
        end
        drain();
        step();
        check("sat_count", err_count, 4'hF);
`endif

        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dif.code_in = make_code($urandom, 1'b0);
            step();
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", dif.out_valid, 1'b0);
        check("mid_rst_in_ready", dif.in_ready, 1'b0);
        check("mid_rst_irq", err_irq, 1'b0);
        q.delete();
        occ     = 0;
        held    = 1'b0;
        m_irq   = 1'b0;
        m_first = '0;
        m_cnt   = 0;
        dif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_no_word", dif.out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/high_speed_bus_ecc_checker.md
HIGH_SPEED_BUS_ECC_CHECKER -- requirements
Module: high_speed_bus_ecc_checker

Interface
REQ-001 Parameter CNT_W, default 16: width of the error counter.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  code_in holds a codeword.
REQ-005 in_ready  output  1  block accepts code_in this cycle.
REQ-006 code_in  input  39  codeword {data[31:0], ecc[6:0]}; data is bits 38:7 and ecc is bits 6:0.
REQ-007 out_valid  output  1  data_out, ecc_error and syndrome are valid.
REQ-008 out_ready  input  1  downstream accepts the output.
REQ-009 data_out  output  32  data field of the codeword, passed through unmodified.
REQ-010 ecc_error  output  1  syndrome of this word is nonzero.
REQ-011 syndrome  output  7  recomputed ECC XOR received ECC.
REQ-012 err_irq  output  1  sticky flag, set by the first errored word.
REQ-013 first_syndrome  output  7  syndrome captured at the first error.
REQ-014 clear  input  1  synchronous clear of err_irq, first_syndrome and err_count.
REQ-015 err_count  output  CNT_W  saturating count of errored words (only with ECC_ERR_COUNT_EN).

Function
REQ-016 The ECC SHALL be recomputed over data d as follows:
- e0 = ^d[31:0]
- e1 = ^d[15:0]
- e2 = ^d[7:0]
- e3 = ^d[3:0]
- e4 = ^d[1:0]
- e5 = d[0]
- e6 = ^{d[31:16], d[7:0]}
REQ-017 The pipeline SHALL have two register stages.
- S1 registers code_in.
- S2 registers data, syndrome and ecc_error computed from S1.
- Latency is 2 cycles from the accepting in_valid&&in_ready edge to out_valid.
REQ-018 Transfer rules:
- A transfer occurs when valid && ready at a rising edge.
- out_valid SHALL stay high, with outputs held stable, until out_ready is seen.
REQ-019 Ready rules:
- s2_ready = !s2_valid || out_ready.
- in_ready = !s1_valid || s2_ready.
- in_ready SHALL NOT depend on in_valid.
REQ-020 With out_ready held high the block SHALL sustain one word per cycle with no bubbles.
REQ-021 Backpressure SHALL lose, duplicate or reorder no words; at most 2 words are held internally.
REQ-022 Errored words SHALL be forwarded with ecc_error=1; no correction is performed.
REQ-023 Error status update:
- The update SHALL occur on the S2 output transfer of an errored word.
- If err_irq=0: set err_irq and capture first_syndrome.
- If err_irq=1: first_syndrome is left unchanged.
REQ-024 If clear coincides with an errored output transfer, clear SHALL win and the cycle's error is not recorded.
REQ-025 The status logic is a two-state FSM:
- CLEAN to LATCHED on an errored output transfer.
- LATCHED to CLEAN on clear.
- err_irq = (state == LATCHED).

Reset
REQ-026 While reset_n is low, the block SHALL drive:
- in_ready = 0
- out_valid = 0
- s1_valid = s2_valid = 0
- data_out = 0, syndrome = 0, ecc_error = 0
- err_irq = 0, first_syndrome = 0, err_count = 0
- FSM state = CLEAN
REQ-027 Reset asserted mid-transfer SHALL discard all words in flight.
REQ-028 in_ready SHALL rise on the first clock edge after reset_n deasserts.

Configuration
REQ-029 With ECC_ERR_COUNT_EN defined:
- err_count increments by 1 per errored output transfer.
- err_count saturates at all-ones.
- clear zeroes err_count, with the same priority as REQ-024.
REQ-030 Without ECC_ERR_COUNT_EN: the err_count port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-031 Package high_speed_bus_ecc_pkg SHALL hold:
- constants DATA_W=32, ECC_W=7, CODE_W=39
- the ECC-generation function
- the status-state typedef
The encoder and checker both use this package.
REQ-032 A single sub-module, ecc_syndrome_calc, SHALL hold the purely combinational syndrome logic between S1 and S2.

Verification
REQ-033 Clean word, no error: code_in=39'h00000000FF (data 0x00000001, ecc 0x7F), out_ready=1 -> after 2 cycles:
- data_out=0x00000001
- syndrome=0
- ecc_error=0
- err_irq=0
REQ-034 Single ECC-bit error: code_in=39'h0000000001 (data 0, ecc 0x01) -> data_out=0, syndrome=7'h01, ecc_error=1; err_irq=1 and first_syndrome=7'h01 on the next cycle.
REQ-035 Data-bit error: code_in=39'h4000000000 (data 0x80000000, ecc 0) -> syndrome=7'h41, ecc_error=1; with first_syndrome=7'h01 already latched, it stays 7'h01.
REQ-036 Backpressure stream:
- Stimulus: stream 10 words while out_ready toggles pseudo-randomly.
- Response: all 10 words come out in order, unchanged.
- Response: in_ready=0 only when both stages are full and out_ready=0.
REQ-037 Clear collision: clear asserted in the same cycle as an errored output transfer -> err_irq=0, first_syndrome=0, err_count=0 afterwards.
REQ-038 Saturation (ECC_ERR_COUNT_EN, CNT_W=4): 20 errored words -> err_count=4'hF.
REQ-039 Reset mid-stream: reset_n pulsed low mid-stream -> out_valid=0 immediately and no stale word appears after release.
